// File: rtl/lcd_arb_pkg.sv
// lcd_arb_pkg: command encodings, FSM states and sizing shared by the LCD command arbiter.
package lcd_arb_pkg;

  localparam int IMG_PIX = 36;
  localparam int WIN_PIX = 9;
  localparam int BYTE_W  = 6;
  localparam int BEAT_W  = 4;

  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(IMG_PIX - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(WIN_PIX - 1);

  typedef enum logic [2:0] {
    CMD_REFRESH = 3'd0,
    CMD_LOAD    = 3'd1,
    CMD_RIGHT   = 3'd2,
    CMD_LEFT    = 3'd3,
    CMD_UP      = 3'd4,
    CMD_DOWN    = 3'd5
  } lcd_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_LOAD,
    ST_WAIT_OUT,
    ST_DONE
  } arb_state_e;

  // Codes above DOWN are reserved and get rejected before reaching the controller.
  function automatic logic cmd_legal(input logic [2:0] cmd);
    return cmd <= CMD_DOWN;
  endfunction

  function automatic logic [1:0] req_mask(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/lcd_rr_arb2.sv
// lcd_rr_arb2: combinational 2-way round-robin picker; the pointer register lives in the parent.
module lcd_rr_arb2
  import lcd_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       gnt_idx,
  output logic       gnt_any
);

  assign gnt_any = |req;
  assign gnt_idx = (req == 2'b11) ? ptr : req[1];

endmodule

// File: rtl/lcd_cmd_arbiter.sv
// lcd_cmd_arbiter: shares one lcd_ctrl datapath between two command requesters.
// Optional readout watchdog is enabled by defining LCD_ARB_TIMEOUT_EN.
module lcd_cmd_arbiter
  import lcd_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [5:0]  req_cmd,
  output logic [1:0]  req_ready,
  input  logic [15:0] req_data,
  output logic [1:0]  data_ready,
  output logic [7:0]  rsp_data,
  output logic [1:0]  rsp_valid,
  output logic [1:0]  rsp_err,
  output logic [2:0]  lcd_cmd,
  output logic        lcd_cmd_valid,
  output logic [7:0]  lcd_datain,
  input  logic        lcd_busy,
  input  logic [7:0]  lcd_dataout,
  input  logic        lcd_output_valid
);

  arb_state_e        state, state_nxt;
  logic              ptr, ptr_nxt;
  logic              gnt, gnt_nxt;
  logic [2:0]        cmd_q, cmd_nxt, win_cmd;
  logic [BYTE_W-1:0] byte_cnt, byte_cnt_nxt;
  logic [BEAT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic              arb_idx, arb_any;
  logic [1:0]        req_ready_nxt, data_ready_nxt, rsp_valid_nxt, rsp_err_nxt;
  logic [7:0]        rsp_data_nxt;
  logic [2:0]        lcd_cmd_nxt;
  logic              lcd_cmd_valid_nxt;

  // A request whose accept pulse is on the bus this cycle is being consumed, not re-raised.
  lcd_rr_arb2 u_arb (
    .req     (req_valid & ~req_ready),
    .ptr     (ptr),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  assign win_cmd    = arb_idx ? req_cmd[5:3] : req_cmd[2:0];
  assign lcd_datain = (state == ST_LOAD) ? (gnt ? req_data[15:8] : req_data[7:0]) : 8'h00;

`ifdef LCD_ARB_TIMEOUT_EN
  localparam int TIMEOUT = 255;
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wdog;
  logic       wdog_fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wdog <= '0;
    else if (state != ST_WAIT_OUT && state_nxt == ST_WAIT_OUT)
      wdog <= '0;
    else if (state == ST_WAIT_OUT || state == ST_DONE)
      wdog <= wdog + 8'd1;
  end

  assign wdog_fire = (state == ST_WAIT_OUT || state == ST_DONE) && (wdog == WDOG_LAST);
`endif

  always_comb begin
    state_nxt         = state;
    ptr_nxt           = ptr;
    gnt_nxt           = gnt;
    cmd_nxt           = cmd_q;
    byte_cnt_nxt      = byte_cnt;
    beat_cnt_nxt      = beat_cnt;
    req_ready_nxt     = '0;
    data_ready_nxt    = '0;
    rsp_valid_nxt     = '0;
    rsp_err_nxt       = '0;
    rsp_data_nxt      = rsp_data;
    lcd_cmd_nxt       = '0;
    lcd_cmd_valid_nxt = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!lcd_busy && arb_any) begin
          gnt_nxt       = arb_idx;
          cmd_nxt       = win_cmd;
          req_ready_nxt = req_mask(arb_idx);
          if (cmd_legal(win_cmd)) begin
            state_nxt         = ST_ISSUE;
            lcd_cmd_nxt       = win_cmd;
            lcd_cmd_valid_nxt = 1'b1;
          end else begin
            rsp_err_nxt = req_mask(arb_idx);
            ptr_nxt     = ~arb_idx;
          end
        end
      end
      ST_ISSUE: begin
        byte_cnt_nxt = '0;
        beat_cnt_nxt = '0;
        if (cmd_q == CMD_LOAD) begin
          state_nxt      = ST_LOAD;
          data_ready_nxt = req_mask(gnt);
        end else begin
          state_nxt = ST_WAIT_OUT;
        end
      end
      ST_LOAD: begin
        if (byte_cnt == BYTE_LAST) begin
          state_nxt = ST_WAIT_OUT;
        end else begin
          byte_cnt_nxt   = byte_cnt + 1'b1;
          data_ready_nxt = req_mask(gnt);
        end
      end
      ST_WAIT_OUT: begin
        if (lcd_output_valid) begin
          rsp_valid_nxt = req_mask(gnt);
          rsp_data_nxt  = lcd_dataout;
          if (beat_cnt == BEAT_LAST)
            state_nxt = ST_DONE;
          else
            beat_cnt_nxt = beat_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        if (!lcd_busy) begin
          state_nxt = ST_IDLE;
          ptr_nxt   = ~gnt;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
`ifdef LCD_ARB_TIMEOUT_EN
    if (wdog_fire) begin
      state_nxt   = ST_IDLE;
      ptr_nxt     = ~gnt;
      rsp_err_nxt = req_mask(gnt);
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      ptr           <= 1'b0;
      gnt           <= 1'b0;
      cmd_q         <= '0;
      byte_cnt      <= '0;
      beat_cnt      <= '0;
      req_ready     <= '0;
      data_ready    <= '0;
      rsp_valid     <= '0;
      rsp_err       <= '0;
      rsp_data      <= '0;
      lcd_cmd       <= '0;
      lcd_cmd_valid <= 1'b0;
    end else begin
      state         <= state_nxt;
      ptr           <= ptr_nxt;
      gnt           <= gnt_nxt;
      cmd_q         <= cmd_nxt;
      byte_cnt      <= byte_cnt_nxt;
      beat_cnt      <= beat_cnt_nxt;
      req_ready     <= req_ready_nxt;
      data_ready    <= data_ready_nxt;
      rsp_valid     <= rsp_valid_nxt;
      rsp_err       <= rsp_err_nxt;
      rsp_data      <= rsp_data_nxt;
      lcd_cmd       <= lcd_cmd_nxt;
      lcd_cmd_valid <= lcd_cmd_valid_nxt;
    end
  end

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// tb_lcd_cmd_arbiter: directed and randomized checks of lcd_cmd_arbiter against a round-robin
// transaction model; the watchdog case is included when LCD_ARB_TIMEOUT_EN is defined.
module tb_lcd_cmd_arbiter;

  localparam int IMG_PIX = 36;
  localparam int WIN_PIX = 9;
  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [5:0]  req_cmd = '0;
  logic [1:0]  req_ready;
  logic [15:0] req_data = '0;
  logic [1:0]  data_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_err;
  logic [2:0]  lcd_cmd;
  logic        lcd_cmd_valid;
  logic [7:0]  lcd_datain;
  logic        lcd_busy = 1'b0;
  logic [7:0]  lcd_dataout = '0;
  logic        lcd_output_valid = 1'b0;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic model_ptr = 1'b0;
  logic [7:0] img [IMG_PIX];
  logic [7:0] beats [WIN_PIX];

  logic       g;
  logic       served0;
  logic [1:0] m;
  logic [2:0] rc;

  lcd_cmd_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_cmd          (req_cmd),
    .req_ready        (req_ready),
    .req_data         (req_data),
    .data_ready       (data_ready),
    .rsp_data         (rsp_data),
    .rsp_valid        (rsp_valid),
    .rsp_err          (rsp_err),
    .lcd_cmd          (lcd_cmd),
    .lcd_cmd_valid    (lcd_cmd_valid),
    .lcd_datain       (lcd_datain),
    .lcd_busy         (lcd_busy),
    .lcd_dataout      (lcd_dataout),
    .lcd_output_valid (lcd_output_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] sel(input logic i);
    return i ? 2'b10 : 2'b01;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] mask, input logic [2:0] c0, input logic [2:0] c1);
    if (mask[0]) begin req_valid[0] = 1'b1; req_cmd[2:0] = c0; end
    if (mask[1]) begin req_valid[1] = 1'b1; req_cmd[5:3] = c1; end
  endtask

  task automatic checkQuiet(input string pfx);
    checkOutput({pfx, "_req_ready"},     32'(req_ready),     32'd0);
    checkOutput({pfx, "_data_ready"},    32'(data_ready),    32'd0);
    checkOutput({pfx, "_rsp_valid"},     32'(rsp_valid),     32'd0);
    checkOutput({pfx, "_rsp_err"},       32'(rsp_err),       32'd0);
    checkOutput({pfx, "_rsp_data"},      32'(rsp_data),      32'd0);
    checkOutput({pfx, "_lcd_cmd"},       32'(lcd_cmd),       32'd0);
    checkOutput({pfx, "_lcd_cmd_valid"}, 32'(lcd_cmd_valid), 32'd0);
    checkOutput({pfx, "_lcd_datain"},    32'(lcd_datain),    32'd0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    req_valid = '0;
    lcd_busy = 1'b0;
    lcd_output_valid = 1'b0;
    #1 checkQuiet("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_ptr = 1'b0;
  endtask

  // Plays both the requester and the controller for one transaction, predicting the winner from the pointer rule.
  task automatic serviceOne(input int budget, input int abort_at, input int stop_after, input bit gaps, output logic gw);
    logic [1:0] pend;
    logic [2:0] ecmd;
    int waited;
    int sent;
    int nb;
`ifdef LCD_ARB_TIMEOUT_EN
    int t0;
`endif
    pend = req_valid;
    gw = (pend == 2'b11) ? model_ptr : pend[1];
    ecmd = gw ? req_cmd[5:3] : req_cmd[2:0];
    req_data = 16'($urandom);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (req_ready == 2'b00 && waited < budget);
    checkOutput("req_ready", 32'(req_ready), 32'(sel(gw)));
    if (req_ready !== sel(gw)) begin
      req_valid = 2'b00;
      return;
    end
    req_valid[gw] = 1'b0;
    if (ecmd > 3'd5) begin
      checkOutput("rsp_err_illegal", 32'(rsp_err), 32'(sel(gw)));
      checkOutput("no_cmd_on_illegal", 32'(lcd_cmd_valid), 32'd0);
      model_ptr = ~gw;
      return;
    end
    checkOutput("lcd_cmd_valid", 32'(lcd_cmd_valid), 32'd1);
    checkOutput("lcd_cmd", 32'(lcd_cmd), 32'(ecmd));
    checkOutput("rsp_err_quiet", 32'(rsp_err), 32'd0);
`ifdef LCD_ARB_TIMEOUT_EN
    t0 = cyc;
`endif
    if (ecmd == 3'd1) begin
      for (int k = 0; k < IMG_PIX; k++) begin
        @(negedge clk);
        if (k == abort_at) begin
          reset = 1'b1;
          #1 checkQuiet("abort");
          model_ptr = 1'b0;
          req_valid = '0;
          @(negedge clk);
          reset = 1'b0;
          return;
        end
        checkOutput("data_ready", 32'(data_ready), 32'(sel(gw)));
        if (gw) req_data[15:8] = img[k];
        else    req_data[7:0]  = img[k];
        #1 checkOutput("lcd_datain", 32'(lcd_datain), 32'(img[k]));
      end
      @(negedge clk);
      checkOutput("data_ready_end", 32'(data_ready), 32'd0);
    end else begin
      lcd_output_valid = 1'b1;
      lcd_dataout = 8'hEE;
      @(negedge clk);
      lcd_output_valid = 1'b0;
      checkOutput("beat_dropped_in_issue", 32'(rsp_valid), 32'd0);
    end
    nb = (stop_after < WIN_PIX) ? stop_after : WIN_PIX;
    sent = 0;
    while (sent < nb) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        @(negedge clk);
        checkOutput("rsp_valid_gap", 32'(rsp_valid), 32'd0);
      end else begin
        lcd_output_valid = 1'b1;
        lcd_dataout = beats[sent];
        @(negedge clk);
        lcd_output_valid = 1'b0;
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(sel(gw)));
        checkOutput("rsp_data", 32'(rsp_data), 32'(beats[sent]));
        sent++;
      end
    end
    if (nb == WIN_PIX) begin
      model_ptr = ~gw;
    end else begin
`ifdef LCD_ARB_TIMEOUT_EN
      waited = 0;
      while (rsp_err == 2'b00 && waited < TIMEOUT + 20) begin
        @(negedge clk);
        waited++;
      end
      checkOutput("wdog_err", 32'(rsp_err), 32'(sel(gw)));
      checkOutput("wdog_delay", 32'(cyc - t0), 32'(TIMEOUT + 1));
      model_ptr = ~gw;
`endif
    end
  endtask

  initial begin
    $display("[TB] start");
    @(negedge clk);
    doReset();

    for (int i = 0; i < IMG_PIX; i++) img[i] = 8'(i);
    for (int i = 0; i < WIN_PIX; i++) beats[i] = 8'(8'h10 + i);
    applyStimulus(2'b01, 3'd1, 3'd0);
    serviceOne(1, -1, WIN_PIX, 1'b0, g);

    doReset();
    for (int i = 0; i < WIN_PIX; i++) beats[i] = 8'($urandom);
    applyStimulus(2'b11, 3'd2, 3'd4);
    serviceOne(1, -1, WIN_PIX, 1'b1, g);
    checkOutput("first_of_pair", 32'(g), 32'd0);
    serviceOne(2, -1, WIN_PIX, 1'b1, g);
    checkOutput("second_of_pair", 32'(g), 32'd1);

    served0 = 1'b0;
    applyStimulus(2'b11, 3'd3, 3'd5);
    for (int i = 0; i < 3; i++) begin
      serviceOne(3, -1, WIN_PIX, 1'b1, g);
      if (g == 1'b0) served0 = 1'b1;
      if (!req_valid[1]) applyStimulus(2'b10, 3'd0, 3'($urandom_range(2, 5)));
    end
    checkOutput("no_starvation", 32'(served0), 32'd1);
    while (req_valid != 2'b00) serviceOne(3, -1, WIN_PIX, 1'b1, g);

    applyStimulus(2'b01, 3'd7, 3'd0);
    serviceOne(2, -1, WIN_PIX, 1'b0, g);
    @(negedge clk);
    checkOutput("illegal_ready_one_cycle", 32'(req_ready), 32'd0);
    checkOutput("illegal_stays_idle", 32'(lcd_cmd_valid), 32'd0);

    lcd_busy = 1'b1;
    applyStimulus(2'b01, 3'd2, 3'd0);
    repeat (4) begin
      @(negedge clk);
      checkOutput("busy_hold_cmd", 32'(lcd_cmd_valid), 32'd0);
      checkOutput("busy_hold_ready", 32'(req_ready), 32'd0);
    end
    lcd_busy = 1'b0;
    serviceOne(1, -1, WIN_PIX, 1'b1, g);

    for (int it = 0; it < 12; it++) begin
      m = 2'($urandom_range(1, 3));
      for (int b = 0; b < 2; b++) begin
        if (m[b] && !req_valid[b]) begin
          rc = ($urandom_range(0, 7) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
          if (b == 0) applyStimulus(2'b01, rc, 3'd0);
          else        applyStimulus(2'b10, 3'd0, rc);
        end
      end
      for (int i = 0; i < IMG_PIX; i++) img[i] = 8'($urandom);
      for (int i = 0; i < WIN_PIX; i++) beats[i] = 8'($urandom);
      serviceOne(3, -1, WIN_PIX, 1'b1, g);
    end
    while (req_valid != 2'b00) serviceOne(3, -1, WIN_PIX, 1'b1, g);

    for (int i = 0; i < IMG_PIX; i++) img[i] = 8'($urandom);
    applyStimulus(2'b10, 3'd0, 3'd1);
    serviceOne(3, 20, WIN_PIX, 1'b0, g);
    applyStimulus(2'b11, 3'd4, 3'd5);
    serviceOne(1, -1, WIN_PIX, 1'b1, g);
    checkOutput("ptr_after_abort", 32'(g), 32'd0);
    serviceOne(2, -1, WIN_PIX, 1'b1, g);

`ifdef LCD_ARB_TIMEOUT_EN
    applyStimulus(2'b01, 3'd2, 3'd0);
    serviceOne(3, -1, 4, 1'b0, g);
    applyStimulus(2'b11, 3'd3, 3'd4);
    serviceOne(3, -1, WIN_PIX, 1'b1, g);
    serviceOne(3, -1, WIN_PIX, 1'b1, g);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
